wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Commit-trace buffer that sits directly downstream of the 5-stage CPU top.
- Consumes the CPU's writeback debug stream (pc, rf write enable, rf address, rf write data) and queues each register-file commit.
- Presents the queued commits on a valid/ready port so a slower checker or UART dumper can drain them without stalling the core.
- Counts commits lost to overflow.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- FILTER_R0, 1, when 1, commits to register 0 are not captured.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_pc  in  32  pc of the committing instruction.
- in_wen  in  1  register-file write enable of the commit.
- in_addr  in  5  destination register.
- in_wdata  in  32  data written.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry this cycle.
- out_pc  out  32  head entry pc; 0 when out_valid=0.
- out_addr  out  5  head entry register; 0 when out_valid=0.
- out_wdata  out  32  head entry data; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one commit was dropped.
- drop_cnt  out  DROP_W  number of dropped commits, saturating.
- clr  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (asynchronous, rst=1): rd_ptr=wr_ptr=0, count=0, out_valid=0, overflow=0, drop_cnt=0. Memory contents are not reset. Data outputs read 0 because out_valid=0.
- Capture condition: cap = in_wen && !(FILTER_R0 && in_addr==0).
- Push: cap && (count<DEPTH || pop). Writes {pc,addr,wdata} at wr_ptr; wr_ptr increments.
- Pop: out_valid && out_ready. rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full: MSBs differ and the low bits are equal. Empty: the pointers are equal.
- Count update: count += push - pop. Push and pop in the same cycle leave count unchanged.
- Full with simultaneous pop: the push is accepted and no drop occurs.
- Latency: a commit pushed at edge N is visible with out_valid=1 after edge N. There is no combinational bypass from in_* to out_*, even when the FIFO is empty.
- Output is first-word-fall-through: out_* read mem[rd_ptr] directly. Head data holds stable while out_valid && !out_ready.
- Drop (cap && count==DEPTH && !pop):
  - the entry is discarded;
  - overflow is set to 1;
  - drop_cnt increments, saturating at all-ones.
- clr: overflow and drop_cnt go to 0 at the next edge. If clr and a drop occur in the same cycle, clr wins and the result is 0. clr does not affect the queue.
- out_ready while out_valid=0 is ignored.
- No state machine beyond the pointers. All flags derive from registered pointers, so there are no combinational paths from in_* to out_valid.

Optional Feature:
- Macro: WB_TRACE_TIMESTAMP_EN.
- Defined:
  - a free-running 32-bit cycle counter cyc is added, reset to 0, incrementing every clk and wrapping at 2^32;
  - each entry also stores the cyc value of its capture cycle;
  - an extra output out_ts [31:0] presents it, and reads 0 when out_valid=0.
- Undefined: no counter, no out_ts port; entry width is 69 bits.

Decomposition:
- Shared package wb_trace_pkg:
  - entry struct typedef trace_entry_t {pc[31:0], addr[4:0], wdata[31:0]};
  - localparam TRACE_ENTRY_W=69;
  - helper function for pointer width.
- One natural sub-module, wb_trace_ram: a DEPTH x entry-width register array with one synchronous write port and an asynchronous read port.
- Pointer, count and drop logic stay in the top.

Test Plan:
- Reset mid-fill: push 3 commits, assert rst asynchronously between edges -> count=0, out_valid=0, overflow=0 immediately, before the next edge.
- Single commit: in_wen=1, pc=0x0000_0040, addr=8, wdata=0xDEAD_BEEF, out_ready=0 -> after one edge out_valid=1 with the same values, count=1; they hold until out_ready=1, then out_valid=0 and count=0.
- R0 filter: in_wen=1, addr=0, FILTER_R0=1 -> count stays 0. With FILTER_R0=0 -> count=1.
- Fill to full then overflow: DEPTH=16, 18 consecutive commits, out_ready=0 -> count=16, overflow=1, drop_cnt=2. Draining yields the first 16 pcs in order.
- Full with push+pop: at count=16, one cycle with a commit and out_ready=1 -> count stays 16, drop_cnt unchanged, the new entry appears last on drain.
- clr vs drop: while full, drive a drop and clr=1 in the same cycle -> overflow=0, drop_cnt=0. Saturation with DROP_W=2 and 5 drops -> drop_cnt=3.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// -----------------------------------------------------------------------------
// wb_trace_pkg
// Shared types and helpers for the writeback commit-trace buffer.
//   trace_entry_t  : one captured register-file commit {pc, addr, wdata}
//   TRACE_ENTRY_W  : packed width of trace_entry_t (69 bits)
//   TRACE_TS_W     : width of the optional capture timestamp
//   trace_ptr_w()  : pointer width for a given depth (one extra wrap bit)
// -----------------------------------------------------------------------------
package wb_trace_pkg;

    localparam int TRACE_ENTRY_W = 69;
    localparam int TRACE_TS_W    = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } trace_entry_t;

    // The extra MSB distinguishes full from empty when the low bits match.
    function automatic int trace_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// -----------------------------------------------------------------------------
// wb_trace_ram
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. The asynchronous read gives the FIFO its first-word-fall-through
// head without an extra cycle. Contents are intentionally not reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write word
//   rd_addr  : read index
//   rd_data  : word at rd_addr (combinational)
// -----------------------------------------------------------------------------
module wb_trace_ram
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = TRACE_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
// Commit-trace buffer behind the CPU writeback stage. Every register-file
// commit (optionally excluding x0) is queued and presented on a valid/ready
// port. Commits arriving while the queue is full and not being drained are
// dropped and counted (sticky overflow flag plus saturating drop counter).
//
// Optional feature macro: WB_TRACE_TIMESTAMP_EN
//   When defined, a free-running 32-bit cycle counter is stored with each
//   entry and presented on out_ts.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_pc/in_wen/in_addr/in_wdata : writeback debug stream from the core
//   out_valid/out_ready           : head-entry handshake (FWFT)
//   out_pc/out_addr/out_wdata     : head entry, forced to 0 when empty
//   out_ts                        : head timestamp (macro builds only)
//   count                         : occupancy 0..DEPTH
//   overflow, drop_cnt            : drop reporting
//   clr                           : synchronous clear of overflow/drop_cnt
// -----------------------------------------------------------------------------
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FILTER_R0 = 1,
    parameter int DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_pc,
    input  logic                     in_wen,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_addr,
    output logic [31:0]              out_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
`ifdef WB_TRACE_TIMESTAMP_EN
    output logic [31:0]              out_ts,
`endif
    input  logic                     clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = trace_ptr_w(DEPTH);
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TRACE_ENTRY_W + TRACE_TS_W;
`else
    localparam int ENTRY_W = TRACE_ENTRY_W;
`endif

    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_cnt_reg;

    logic              empty, full, cap, push, pop, drop;
    trace_entry_t      wr_entry, rd_entry;
    logic [ENTRY_W-1:0] wr_word, rd_word;

    // Status derives only from registered pointers, so nothing on in_*
    // reaches out_valid or count combinationally.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign cap  = in_wen && !((FILTER_R0 != 0) && (in_addr == 5'd0));
    assign pop  = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign wr_ptr_next = wr_ptr_reg + PW'(push);
    assign rd_ptr_next = rd_ptr_reg + PW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // clr has priority over a drop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clr) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != '1) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
            end
        end
    end

    assign wr_entry.pc    = in_pc;
    assign wr_entry.addr  = in_addr;
    assign wr_entry.wdata = in_wdata;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] cyc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_reg <= '0;
        end else begin
            cyc_reg <= cyc_reg + 32'd1;
        end
    end

    assign wr_word = {cyc_reg, wr_entry};
    assign out_ts  = out_valid ? rd_word[ENTRY_W-1 -: TRACE_TS_W] : '0;
`else
    assign wr_word = wr_entry;
`endif

    wb_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_word)
    );

    assign rd_entry = trace_entry_t'(rd_word[TRACE_ENTRY_W-1:0]);

    assign out_valid = !empty;
    assign out_pc    = out_valid ? rd_entry.pc    : '0;
    assign out_addr  = out_valid ? rd_entry.addr  : '0;
    assign out_wdata = out_valid ? rd_entry.wdata : '0;

    // Pointer difference modulo 2*DEPTH is the occupancy.
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_fifo
// Two instances share one stimulus stream:
//   dut_a : DEPTH=16, FILTER_R0=1, DROP_W=16
//   dut_b : DEPTH=4,  FILTER_R0=0, DROP_W=2  (x0 capture, fast saturation)
// A queue-based model tracks each instance; a negedge process compares every
// output each cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_pc = '0;
    logic        in_wen = 1'b0;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        out_ready = 1'b0;
    logic        clr = 1'b0;

    logic        va, vb;
    logic [31:0] pca, pcb, wda, wdb;
    logic [4:0]  ada, adb;
    logic [4:0]  cnta;
    logic [2:0]  cntb;
    logic        ovfa, ovfb;
    logic [15:0] dra;
    logic [1:0]  drb;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] tsa, tsb;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(16), .FILTER_R0(1), .DROP_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .in_pc(in_pc), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(va), .out_ready(out_ready),
        .out_pc(pca), .out_addr(ada), .out_wdata(wda),
        .count(cnta), .overflow(ovfa), .drop_cnt(dra),
`ifdef WB_TRACE_TIMESTAMP_EN
        .out_ts(tsa),
`endif
        .clr(clr)
    );

    wb_trace_fifo #(.DEPTH(4), .FILTER_R0(0), .DROP_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_pc(in_pc), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(vb), .out_ready(out_ready),
        .out_pc(pcb), .out_addr(adb), .out_wdata(wdb),
        .count(cntb), .overflow(ovfb), .drop_cnt(drb),
`ifdef WB_TRACE_TIMESTAMP_EN
        .out_ts(tsb),
`endif
        .clr(clr)
    );

    // ------------------------------------------------------------ model
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] ts;
    } ent_t;

    ent_t        mq [2][$];
    int          m_drop [2];
    bit          m_ovf  [2];
    logic [31:0] m_cyc;

    function automatic int p_depth(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic bit p_filt(input int k);
        return (k == 0);
    endfunction
    function automatic int p_dmax(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_drop[k] = 0;
            m_ovf[k]  = 1'b0;
        end
        m_cyc = '0;
    endtask

    // Applies one rising edge worth of behaviour using the inputs held now.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit   pop_b, cap_b, push_b, drop_b;
            ent_t e;
            pop_b  = (mq[k].size() > 0) && out_ready;
            cap_b  = in_wen && !(p_filt(k) && in_addr == 5'd0);
            push_b = cap_b && ((mq[k].size() < p_depth(k)) || pop_b);
            drop_b = cap_b && !push_b;
            if (pop_b) void'(mq[k].pop_front());
            if (push_b) begin
                e.pc = in_pc; e.addr = in_addr; e.wdata = in_wdata; e.ts = m_cyc;
                mq[k].push_back(e);
            end
            if (clr) begin
                m_ovf[k]  = 1'b0;
                m_drop[k] = 0;
            end else if (drop_b) begin
                m_ovf[k] = 1'b1;
                if (m_drop[k] < p_dmax(k)) m_drop[k]++;
            end
        end
        m_cyc = m_cyc + 32'd1;
    endtask

    // ------------------------------------------------------------ checking
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int k, input logic v, input logic [31:0] pc,
                           input logic [4:0] ad, input logic [31:0] wd,
                           input logic [31:0] ts, input int cnt,
                           input logic ov, input int dr);
        ent_t e;
        bit   has;
        has = (mq[k].size() > 0);
        if (has) e = mq[k][0];
        else begin e.pc = '0; e.addr = '0; e.wdata = '0; e.ts = '0; end
        chk($sformatf("d%0d_valid", k), 64'(v), 64'(has));
        chk($sformatf("d%0d_pc", k), 64'(pc), 64'(e.pc));
        chk($sformatf("d%0d_addr", k), 64'(ad), 64'(e.addr));
        chk($sformatf("d%0d_wdata", k), 64'(wd), 64'(e.wdata));
`ifdef WB_TRACE_TIMESTAMP_EN
        chk($sformatf("d%0d_ts", k), 64'(ts), 64'(e.ts));
`else
        if (ts != 32'd0) chk($sformatf("d%0d_ts_tie", k), 64'(ts), 64'd0);
`endif
        chk($sformatf("d%0d_count", k), 64'(cnt), 64'(mq[k].size()));
        chk($sformatf("d%0d_overflow", k), 64'(ov), 64'(m_ovf[k]));
        chk($sformatf("d%0d_drop_cnt", k), 64'(dr), 64'(m_drop[k]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
`ifdef WB_TRACE_TIMESTAMP_EN
            cmp_dut(0, va, pca, ada, wda, tsa, 32'(cnta), ovfa, 32'(dra));
            cmp_dut(1, vb, pcb, adb, wdb, tsb, 32'(cntb), ovfb, 32'(drb));
`else
            cmp_dut(0, va, pca, ada, wda, 32'd0, 32'(cnta), ovfa, 32'(dra));
            cmp_dut(1, vb, pcb, adb, wdb, 32'd0, 32'(cntb), ovfb, 32'(drb));
`endif
        end
    end

    // ------------------------------------------------------------ driving
    // Returns just after the falling edge; inputs are changed only here.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] pc,
                         input logic [4:0] a, input logic [31:0] d);
        in_wen = w; in_pc = pc; in_addr = a; in_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          rp;

        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_valid_a", 64'(va), 64'd0);
        chk("reset_count_a", 64'(cnta), 64'd0);
        chk("reset_overflow_a", 64'(ovfa), 64'd0);
        chk("reset_drop_a", 64'(dra), 64'd0);
        chk("reset_pc_a", 64'(pca), 64'd0);

        // Reset asserted between edges with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 5'(i + 1), $urandom);
            tick();
        end
        idle();
        chk("fill3_count_a", 64'(cnta), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_count_a", 64'(cnta), 64'd0);
        chk("async_rst_valid_a", 64'(va), 64'd0);
        chk("async_rst_overflow_a", 64'(ovfa), 64'd0);
        chk("async_rst_count_b", 64'(cntb), 64'd0);
        chk("async_rst_valid_b", 64'(vb), 64'd0);
        tick();
        rst = 1'b0;

        // Single commit held until accepted.
        drive(1'b1, 32'h0000_0040, 5'd8, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        tick();
        idle();
        chk("single_valid", 64'(va), 64'd1);
        chk("single_pc", 64'(pca), 64'h40);
        chk("single_addr", 64'(ada), 64'd8);
        chk("single_wdata", 64'(wda), 64'hDEAD_BEEF);
        chk("single_count", 64'(cnta), 64'd1);
        repeat (3) tick();
        chk("hold_pc", 64'(pca), 64'h40);
        chk("hold_wdata", 64'(wda), 64'hDEAD_BEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drained_valid", 64'(va), 64'd0);
        chk("single_drained_count", 64'(cnta), 64'd0);
        chk("single_drained_pc", 64'(pca), 64'd0);

        // x0 commit: filtered in dut_a, captured in dut_b.
        drive(1'b1, 32'h80, 5'd0, 32'h1234);
        tick();
        idle();
        chk("r0_filtered_count_a", 64'(cnta), 64'd0);
        chk("r0_kept_count_b", 64'(cntb), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 18 commits into a non-draining queue.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 5'(i + 1), 32'(i));
            tick();
        end
        idle();
        chk("full_count_a", 64'(cnta), 64'd16);
        chk("full_overflow_a", 64'(ovfa), 64'd1);
        chk("full_drop_a", 64'(dra), 64'd2);
        chk("full_head_a", 64'(pca), 64'h100);
        chk("model_full_a", 64'(mq[0].size()), 64'd16);
        chk("full_count_b", 64'(cntb), 64'd4);
        chk("sat_drop_b", 64'(drb), 64'd3);

        // Full with simultaneous push and pop.
        drive(1'b1, 32'h200, 5'd9, 32'h55);
        out_ready = 1'b1;
        tick();
        idle();
        out_ready = 1'b0;
        chk("pushpop_count_a", 64'(cnta), 64'd16);
        chk("pushpop_drop_a", 64'(dra), 64'd2);
        chk("pushpop_head_a", 64'(pca), 64'h104);

        // clr and drop in the same cycle.
        drive(1'b1, 32'h300, 5'd10, 32'h0);
        clr = 1'b1;
        tick();
        idle();
        clr = 1'b0;
        chk("clr_overflow_a", 64'(ovfa), 64'd0);
        chk("clr_drop_a", 64'(dra), 64'd0);
        chk("clr_count_a", 64'(cnta), 64'd16);
        chk("clr_drop_b", 64'(drb), 64'd0);

        // Drain in order; the push+pop entry comes last.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 32'h104 + 32'(4 * i) : 32'h200;
            chk($sformatf("drain_pc_%0d", i), 64'(pca), 64'(exp_pc));
            tick();
        end
        out_ready = 1'b0;
        chk("drained_valid_a", 64'(va), 64'd0);

        // Randomized traffic with varying drain pressure.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 3)
                0:       rp = 10;
                1:       rp = 50;
                default: rp = 90;
            endcase
            drive(($urandom % 100) < 70, $urandom,
                  (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            out_ready = ($urandom % 100) < rp;
            clr = ($urandom % 100) < 2;
            tick();
        end
        idle();
        out_ready = 1'b0;
        clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
